// File: rtl/reg_file_pkg.sv
// Shared widths, opcodes and FSM state encoding for the register-file access controller.
package reg_file_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    OpRsv   = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpAdd   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdIssue = 3'd1,
    StRdWait  = 3'd2,
    StWrIssue = 3'd3,
    StResp    = 3'd4
  } state_e;

endpackage

// File: rtl/reg_file_access_ctrl_if.sv
// Host-side request/response handshake bundle for reg_file_access_ctrl.
interface reg_file_access_ctrl_if #(
  parameter int unsigned DataW = reg_file_pkg::DATA_W,
  parameter int unsigned AddrW = reg_file_pkg::ADDR_W
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AddrW-1:0] req_addr;
  logic [DataW-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DataW-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport host (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport ctrl (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

endinterface

// File: rtl/reg_file_access_ctrl.sv
// Single-command front-end for the 8x16 register file: READ, WRITE and ADD (read-modify-write),
// sequencing the file's one-cycle registered read latency and returning one response per command.
module reg_file_access_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  reg_file_access_ctrl_if.ctrl host_io,
  output logic                 rf_rd_en_o,
  output logic                 rf_wr_en_o,
  output logic [AddrW-1:0]     rf_addr_o,
  output logic [DataW-1:0]     rf_wr_data_o,
  input  logic [DataW-1:0]     rf_rd_data_i
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic [DataW-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;
  logic [DataW:0]   sum;

  assign sum = {1'b0, rf_rd_data_i} + {1'b0, data_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpRsv;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (host_io.req_valid) begin
          op_d        = op_e'(host_io.req_op);
          addr_d      = host_io.req_addr;
          data_d      = host_io.req_data;
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b0;
          case (op_e'(host_io.req_op))
            OpRead, OpAdd: state_d = StRdIssue;
            OpWrite:       state_d = StWrIssue;
            default: begin
              state_d   = StResp;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        // ADD reuses data_q to carry the sum into the write-issue cycle.
        if (op_q == OpAdd) begin
          data_d      = sum[DataW-1:0];
          rsp_carry_d = sum[DataW];
          state_d     = StWrIssue;
        end else begin
          rsp_data_d = rf_rd_data_i;
          state_d    = StResp;
        end
      end
      StWrIssue: begin
        rsp_data_d = data_q;
        state_d    = StResp;
      end
      StResp: begin
        if (host_io.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign host_io.req_ready = (state_q == StIdle);
  assign host_io.rsp_valid = (state_q == StResp);
  assign host_io.rsp_data  = rsp_data_q;
  assign host_io.rsp_carry = rsp_carry_q;
  assign host_io.rsp_err   = rsp_err_q;

  // RF pins depend only on registered state so the file never sees a host-side glitch.
  assign rf_rd_en_o   = (state_q == StRdIssue);
  assign rf_wr_en_o   = (state_q == StWrIssue);
  assign rf_addr_o    = (rf_rd_en_o || rf_wr_en_o) ? addr_q : '0;
  assign rf_wr_data_o = rf_wr_en_o ? data_q : '0;

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Scoreboard bench for reg_file_access_ctrl with a behavioural 8x16 register file attached.
module tb_reg_file_access_ctrl;
  import reg_file_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        carry;
    logic        err;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rf_rd_en, rf_wr_en;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wr_data;
  logic [15:0] rf_rd_data = '0;
  logic [15:0] rf_mem [8] = '{default: '0};
  logic [15:0] exp_mem [8];
  rsp_t        exp_q [$];
  int          n_total = 0;
  int          n_pass = 0;
  int          en_cnt = 0;
  int          both_cnt = 0;
  int          cyc = 0;

  reg_file_access_ctrl_if ifc ();

  reg_file_access_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .host_io     (ifc),
    .rf_rd_en_o  (rf_rd_en),
    .rf_wr_en_o  (rf_wr_en),
    .rf_addr_o   (rf_addr),
    .rf_wr_data_o(rf_wr_data),
    .rf_rd_data_i(rf_rd_data)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_addr];
    if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rf_rd_en || rf_wr_en) en_cnt = en_cnt + 1;
      if (rf_rd_en && rf_wr_en) both_cnt = both_cnt + 1;
    end
  end

  function automatic rsp_t model(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d);
    rsp_t r;
    logic [16:0] s;
    r = '0;
    case (op)
      2'b01: r.data = exp_mem[a];
      2'b10: begin
        r.data = d;
        exp_mem[a] = d;
      end
      2'b11: begin
        s = {1'b0, exp_mem[a]} + {1'b0, d};
        r.data = s[15:0];
        r.carry = s[16];
        exp_mem[a] = s[15:0];
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Returns 1ns after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                       input bit track);
    int n = 0;
    ifc.req_valid = 1'b1;
    ifc.req_op = op;
    ifc.req_addr = a;
    ifc.req_data = d;
    while (!ifc.req_ready && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    n_total++;
    if (ifc.req_ready !== 1'b1) begin
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", ifc.req_ready, n);
    end else begin
      n_pass++;
      @(posedge clk_i); #1;
      if (track) exp_q.push_back(model(op, a, d));
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges, output rsp_t got);
    int n = 0;
    while (!ifc.rsp_valid && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    edges = (ifc.rsp_valid === 1'b1) ? n : -1;
    got = {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err};
  endtask

  task automatic ack();
    ifc.rsp_ready = 1'b1;
    @(posedge clk_i); #1;
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_total++;
    if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b, required 1 0", ifc.req_ready,
               ifc.rsp_valid);
    end else n_pass++;
    n_total++;
    if ({ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err} !== 18'h0) begin
      $display("FAIL reset_rsp: data=%h carry=%b err=%b, required 0", ifc.rsp_data,
               ifc.rsp_carry, ifc.rsp_err);
    end else n_pass++;
    n_total++;
    if ({rf_rd_en, rf_wr_en, rf_addr, rf_wr_data} !== 21'h0) begin
      $display("FAIL reset_rf: rd=%b wr=%b addr=%h wdata=%h, required 0", rf_rd_en, rf_wr_en,
               rf_addr, rf_wr_data);
    end else n_pass++;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_total++;
    if ({rf_rd_en, rf_wr_en} !== 2'b00) begin
      $display("FAIL post_reset_en: rd=%b wr=%b, required 0 0", rf_rd_en, rf_wr_en);
    end else n_pass++;
  endtask

  task automatic test_write();
    int e;
    rsp_t g, x;
    issue(2'b10, 3'd3, 16'hA5A5, 1'b1);
    n_total++;
    if ({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data} !== {2'b10, 3'd3, 16'hA5A5}) begin
      $display("FAIL write_rf: wr=%b rd=%b addr=%h wdata=%h, required 1 0 3 a5a5", rf_wr_en,
               rf_rd_en, rf_addr, rf_wr_data);
    end else n_pass++;
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (e !== 1) $display("FAIL write_latency: edges=%0d, required 1", e);
    else n_pass++;
    n_total++;
    if (g !== x) $display("FAIL write_rsp: got=%h, required %h", g, x);
    else n_pass++;
    ack();
  endtask

  task automatic test_read();
    int e, en0;
    rsp_t g, x;
    issue(2'b10, 3'd5, 16'h1234, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (g !== x) $display("FAIL read_setup_rsp: got=%h, required %h", g, x);
    else n_pass++;
    ack();
    en0 = en_cnt;
    issue(2'b01, 3'd5, 16'h0000, 1'b1);
    n_total++;
    if ({rf_rd_en, rf_wr_en, rf_addr} !== {2'b10, 3'd5}) begin
      $display("FAIL read_rf: rd=%b wr=%b addr=%h, required 1 0 5", rf_rd_en, rf_wr_en, rf_addr);
    end else n_pass++;
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (e !== 2) $display("FAIL read_latency: edges=%0d, required 2", e);
    else n_pass++;
    n_total++;
    if (g !== x) $display("FAIL read_rsp: got=%h, required %h", g, x);
    else n_pass++;
    n_total++;
    if (en_cnt - en0 !== 1) $display("FAIL read_en_cycles: %0d, required 1", en_cnt - en0);
    else n_pass++;
    ack();
  endtask

  task automatic test_add_wrap();
    int e;
    rsp_t g, x;
    issue(2'b10, 3'd7, 16'hFFFF, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    ack();
    issue(2'b11, 3'd7, 16'h0002, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (e !== 3) $display("FAIL add_latency: edges=%0d, required 3", e);
    else n_pass++;
    n_total++;
    if (g !== x) $display("FAIL add_rsp: got=%h, required %h", g, x);
    else n_pass++;
    n_total++;
    if (rf_mem[7] !== 16'h0001) $display("FAIL add_rf_mem: %h, required 0001", rf_mem[7]);
    else n_pass++;
    ack();
    issue(2'b01, 3'd7, 16'h0000, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (g !== x) $display("FAIL add_readback: got=%h, required %h", g, x);
    else n_pass++;
    ack();
  endtask

  task automatic test_reserved();
    int e, en0;
    rsp_t g, x;
    en0 = en_cnt;
    issue(2'b00, 3'd2, 16'hBEEF, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (e !== 0) $display("FAIL rsv_latency: edges=%0d, required 0", e);
    else n_pass++;
    n_total++;
    if (g !== x) $display("FAIL rsv_rsp: got=%h, required %h", g, x);
    else n_pass++;
    ack();
    n_total++;
    if (en_cnt !== en0) $display("FAIL rsv_rf_access: %0d enable cycles, required 0", en_cnt - en0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int e, en0;
    rsp_t g, x;
    issue(2'b10, 3'd1, 16'h0F0F, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    en0 = en_cnt;
    ifc.req_valid = 1'b1;
    ifc.req_op = 2'b01;
    ifc.req_addr = 3'd1;
    ifc.req_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      n_total++;
      if (ifc.req_ready !== 1'b0 || ifc.rsp_valid !== 1'b1 || g !== x
          || {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err} !== x) begin
        $display("FAIL stall_hold[%0d]: ready=%b valid=%b rsp=%h, required 0 1 %h", i,
                 ifc.req_ready, ifc.rsp_valid, {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err}, x);
      end else n_pass++;
    end
    n_total++;
    if (en_cnt !== en0) $display("FAIL stall_no_accept: %0d enable cycles, required 0", en_cnt - en0);
    else n_pass++;
    ack();
    n_total++;
    if (ifc.req_ready !== 1'b1) $display("FAIL stall_release: req_ready=%b, required 1", ifc.req_ready);
    else n_pass++;
    exp_q.push_back(model(2'b01, 3'd1, 16'h0000));
    @(posedge clk_i); #1;
    ifc.req_valid = 1'b0;
    n_total++;
    if (rf_rd_en !== 1'b1) $display("FAIL stall_accept_rd: rd=%b, required 1", rf_rd_en);
    else n_pass++;
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (e !== 2 || g !== x) $display("FAIL stall_read_rsp: edges=%0d got=%h, required 2 %h", e, g, x);
    else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [7] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [2:0]  adr [7] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd4, 3'd4, 3'd4};
    logic [15:0] dat [7] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0001, 16'h7FFF, 16'h0};
    int          lat [7] = '{2, 4, 3, 1, 2, 4, 3};
    int          prev_cyc, e;
    rsp_t        g, x;
    prev_cyc = 0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], adr[i], dat[i], 1'b1);
      if (i > 0) begin
        n_total++;
        if (cyc - prev_cyc !== lat[i-1] + 1) begin
          $display("FAIL b2b_interval[%0d]: %0d cycles, required %0d", i, cyc - prev_cyc,
                   lat[i-1] + 1);
        end else n_pass++;
      end
      prev_cyc = cyc;
      wait_rsp(e, g);
      x = exp_q.pop_front();
      n_total++;
      if (e !== lat[i] - 1 || g !== x) begin
        $display("FAIL b2b_rsp[%0d]: edges=%0d got=%h, required %0d %h", i, e, g, lat[i] - 1, x);
      end else n_pass++;
    end
    @(posedge clk_i); #1;
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_add();
    int e;
    rsp_t g, x;
    issue(2'b10, 3'd6, 16'h0100, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    ack();
    issue(2'b11, 3'd6, 16'h0001, 1'b0);
    @(posedge clk_i); #1;
    n_total++;
    if ({rf_rd_en, rf_wr_en} !== 2'b00) begin
      $display("FAIL rdwait_en: rd=%b wr=%b, required 0 0", rf_rd_en, rf_wr_en);
    end else n_pass++;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_total++;
    if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err, rf_rd_en,
         rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 40'h0}) begin
      $display("FAIL abort_outputs: ready=%b valid=%b rsp=%h rd=%b wr=%b addr=%h wdata=%h",
               ifc.req_ready, ifc.rsp_valid, {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_err},
               rf_rd_en, rf_wr_en, rf_addr, rf_wr_data);
    end else n_pass++;
    rst_ni = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      n_total++;
      if (rf_wr_en !== 1'b0 || ifc.rsp_valid !== 1'b0) begin
        $display("FAIL abort_quiet: wr=%b valid=%b, required 0 0", rf_wr_en, ifc.rsp_valid);
      end else n_pass++;
    end
    n_total++;
    if (rf_mem[6] !== 16'h0100) $display("FAIL abort_mem: %h, required 0100", rf_mem[6]);
    else n_pass++;
    issue(2'b01, 3'd6, 16'h0000, 1'b1);
    wait_rsp(e, g);
    x = exp_q.pop_front();
    n_total++;
    if (g !== x) $display("FAIL abort_readback: got=%h, required %h", g, x);
    else n_pass++;
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    ifc.req_valid = 1'b0;
    ifc.req_op = 2'b00;
    ifc.req_addr = '0;
    ifc.req_data = '0;
    ifc.rsp_ready = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_write();
    test_read();
    test_add_wrap();
    test_reserved();
    test_stall();
    test_back_to_back();
    test_reset_mid_add();
    n_total++;
    if (both_cnt !== 0) $display("FAIL rd_wr_exclusive: %0d cycles with both, required 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
